poly_tone_pwm: RTL
==================

// Module: poly_tone_pwm
// PURPOSE
//  Multi-channel square-wave tone generator with a mixed, glitch-free PWM DAC output.
//  Each channel has a programmable period (in samples), volume and enable.
//  Enabled channels are summed per sample, and the sum drives the duty of an N-bit PWM frame.
//  Sits under tt_um_soundgen, replacing the fixed-duty dac; pwm_out drives the audio pin.
// PARAMETERS
//  N        8   PWM resolution; frame = 2**N clk cycles = one sample period
//  CHANNELS 4   number of tone channels (>=1)
//  DIV_W    12  width of per-channel period register (half-period, in samples)
//  VOL_W    4   width of per-channel volume
//  Constraint: S = VOL_W + $clog2(CHANNELS) <= N (elaboration error otherwise)
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  ena          in   1      run enable; low = freeze all state, pwm_out forced 0
//  cfg_we       in   1      config write strobe, one cycle
//  cfg_ch       in   $clog2(CHANNELS)+1  channel index to write
//  cfg_period   in   DIV_W  half-period in samples; 0 = channel silent
//  cfg_vol      in   VOL_W  channel amplitude
//  cfg_en       in   1      channel enable
//  pwm_out      out  1      registered PWM audio output
//  sample_tick  out  1      one-cycle pulse, last cycle of each PWM frame
// BEHAVIOUR
//  Reset (async, rst_n=0): pwm_cnt=0, duty=0, pwm_out=0, sample_tick=0.
//   All channel period/vol/en/cnt/square registers are 0. Takes effect immediately, mid-frame included.
//  pwm_cnt: N-bit, increments every clk while ena=1, wraps 2**N-1 -> 0.
//  sample_tick = ena & (pwm_cnt == 2**N-1); registered so it is high in exactly that cycle.
//  pwm_out registered: pwm_out(k+1) = (pwm_cnt(k) < duty(k)).
//   Result: exactly duty high cycles per frame, with no mid-frame duty change.
//  Config write (cfg_we=1, ena don't-care): if cfg_ch >= CHANNELS, the write is ignored.
//   Otherwise period/vol/en of channel cfg_ch are updated at the clock edge.
//   Any transition of en 0->1 (or write with en=1 onto a disabled channel) also sets cnt=0, square=0.
//   Writing en=0 clears cnt and square.
//  Channel step, at each sample_tick edge, per enabled channel with period!=0:
//   cnt==0 -> cnt<=period-1, square<=~square; else cnt<=cnt-1.
//   Half-period = period samples; full tone period = 2*period samples.
//  Period change on a running channel: cnt is not reset; the new value is used at the next reload.
//  Simultaneous cfg write and tick on the same channel: the tick uses the pre-write registers.
//   The written values take effect from the next tick.
//  Contribution c_i = (en_i & period_i!=0 & square_i) ? vol_i : 0.
//  mix = sum c_i, width S. No overflow possible.
//  duty is loaded at the sample_tick edge with mix << (N-S), computed from pre-tick square states.
//   This gives one sample of latency from a square toggle to audible duty.
//  Max duty = CHANNELS*(2**VOL_W-1) << (N-S), which is < 2**N, so pwm_out never stays high for a whole frame.
//  ena=0: pwm_cnt, cnt, square, duty and sample_tick are held or cleared as follows.
//   Counters and squares hold; sample_tick=0; pwm_out=0 from the next edge.
//   Config writes still apply.
//   On ena 0->1, operation resumes from the held pwm_cnt.
// TESTING
//  1 Reset mid-frame with duty=60 -> pwm_out and sample_tick are 0 in the same cycle.
//    All channels silent after release; 0 high cycles per frame.
//  2 ch0 period=1 vol=15 en=1, others off (defaults) -> high cycles per frame alternate 60,0,60,0.
//    sample_tick period is 256 clk.
//  3 ch0..3 period=3 vol=15 en=1, all written in the same frame -> frames show 240 high cycles x3, then 0 x3, repeating.
//  4 ch1 period=0 vol=15 en=1 -> 0 high cycles.
//    Then rewrite period=2 -> toggling begins; 2 frames of 60, then 2 frames of 0.
//  5 Write cfg_ch=5 (CHANNELS=4) with en=1 vol=15 -> no register change; output unchanged.
//  6 Drop ena for 1000 cycles mid-frame in test 2 -> pwm_out=0 and no sample_tick.
//    After resume, the frame completes with the held pwm_cnt and the alternation continues in phase.

Source files
------------

// File: rtl/poly_tone_pwm_if.sv
// Configuration bus for poly_tone_pwm: one-cycle write
// strobe carrying channel index, half-period, volume and enable.
interface poly_tone_pwm_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 12,
    parameter int VOL_W    = 4
);
    localparam int CH_W = $clog2(CHANNELS) + 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_period;
    logic [VOL_W-1:0] cfg_vol;
    logic             cfg_en;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_vol, cfg_en
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_period, cfg_vol, cfg_en
    );
endinterface

// File: rtl/poly_tone_pwm.sv
// Multi-channel square-wave tone generator mixed into a
// glitch-free N-bit PWM DAC; duty only changes at frame end.
module poly_tone_pwm #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 12,
    parameter int VOL_W    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    poly_tone_pwm_if.slave cfg,
    output logic           pwm_out,
    output logic           sample_tick
);
    localparam int CH_W = $clog2(CHANNELS) + 1;
    localparam int S    = VOL_W + $clog2(CHANNELS);
    localparam logic [N-1:0] CNT_MAX = '1;

    if (S > N) begin : g_bad_cfg
        $error("poly_tone_pwm: VOL_W + clog2(CHANNELS) exceeds N");
    end

    logic [N-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N-1:0] duty_q, duty_d;
    logic         pwm_out_q, pwm_out_d;
    logic         tick_q, tick_d;

    logic [CHANNELS-1:0][DIV_W-1:0] per_q, per_d;
    logic [CHANNELS-1:0][VOL_W-1:0] vol_q, vol_d;
    logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            en_q, en_d;
    logic [CHANNELS-1:0]            sq_q, sq_d;

    logic         fire;
    logic [S-1:0] mix;

    // fire marks the last cycle of a running frame
    always_comb begin
        fire      = ena && (pwm_cnt_q == CNT_MAX);
        pwm_cnt_d = ena ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        tick_d    = ena && (pwm_cnt_d == CNT_MAX);
        pwm_out_d = ena && (pwm_cnt_q < duty_q);
        mix       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (en_q[i] && (per_q[i] != '0) && sq_q[i]) begin
                mix = mix + S'(vol_q[i]);
            end
        end
        duty_d = fire ? (N'(mix) << (N - S)) : duty_q;
    end

    // tick steps use pre-write state; writes land afterwards
    always_comb begin
        per_d = per_q;
        vol_d = vol_q;
        en_d  = en_q;
        cnt_d = cnt_q;
        sq_d  = sq_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (fire && en_q[i] && (per_q[i] != '0)) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i] = per_q[i] - 1'b1;
                    sq_d[i]  = ~sq_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
            if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))) begin
                per_d[i] = cfg.cfg_period;
                vol_d[i] = cfg.cfg_vol;
                en_d[i]  = cfg.cfg_en;
                if (!cfg.cfg_en || !en_q[i]) begin
                    cnt_d[i] = '0;
                    sq_d[i]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_out_q <= 1'b0;
            tick_q    <= 1'b0;
            per_q     <= '0;
            vol_q     <= '0;
            en_q      <= '0;
            cnt_q     <= '0;
            sq_q      <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
            tick_q    <= tick_d;
            per_q     <= per_d;
            vol_q     <= vol_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            sq_q      <= sq_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign sample_tick = tick_q;
endmodule
